// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_pkg
//  Description : Shared definitions for the serial-in / parallel-out
//                deserializer: counter width helper and output buffer
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sipo_pkg;

    // Width of a counter that indexes 0..width-1 (never narrower than 1 bit).
    function automatic int CNT_W(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // One-entry output buffer state.
    typedef enum logic [0:0] {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_shift_core.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_shift_core
//  Description : Shift register and bit counter. Collects qualified serial
//                bits and flags word_done (combinationally, in the cycle of
//                the last bit) together with the completed word.
//  Ports       : clk, reset        - clock, async active-high reset
//                serial_in         - serial data bit
//                serial_valid      - bit strobe
//                frame_start       - current bit is bit 0 of a new word
//                word_done         - this strobe completes a word
//                word              - completed word (valid with word_done)
//                bit_count         - bits held in the partial word
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            serial_in,
    input  logic                            serial_valid,
    input  logic                            frame_start,
    output logic                            word_done,
    output logic [DATA_WIDTH-1:0]           word,
    output logic [CNT_W(DATA_WIDTH)-1:0]    bit_count
);

    localparam int                C_CNT_W = CNT_W(DATA_WIDTH);
    localparam logic [C_CNT_W-1:0] c_LAST = C_CNT_W'(DATA_WIDTH - 1);
    localparam logic [C_CNT_W-1:0] c_ONE  = C_CNT_W'(1);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [C_CNT_W-1:0]    r_count;
    logic [DATA_WIDTH-1:0] w_base_shift;
    logic [C_CNT_W-1:0]    w_base_count;
    logic [DATA_WIDTH-1:0] w_next_shift;
    logic                  w_done;

    // A frame_start bit restarts assembly: the partial word is discarded and
    // the incoming bit is treated as bit 0 of an empty register.
    always_comb begin
        w_base_shift = frame_start ? '0 : r_shift;
        w_base_count = frame_start ? '0 : r_count;
    end

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_next_shift = {w_base_shift[DATA_WIDTH-2:0], serial_in};
        end else begin : g_lsb_first
            assign w_next_shift = {serial_in, w_base_shift[DATA_WIDTH-1:1]};
        end
    endgenerate

    assign w_done = serial_valid && (w_base_count == c_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (serial_valid) begin
            r_shift <= w_done ? '0 : w_next_shift;
            r_count <= w_done ? '0 : (w_base_count + c_ONE);
        end
    end

    assign word_done = w_done;
    assign word      = w_next_shift;
    assign bit_count = r_count;

endmodule : sipo_shift_core
`default_nettype wire

// File: rtl/sipo_deser.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_deser
//  Description : Serial-in, parallel-out deserializer with a one-entry
//                valid/ready output buffer and a sticky overrun flag for
//                words dropped under backpressure.
//  Ports       : clk, reset        - clock, async active-high reset
//                serial_in         - serial data bit
//                serial_valid      - bit strobe
//                frame_start       - resync marker, qualified by serial_valid
//                data_out          - buffered word
//                data_valid        - buffer holds a word
//                data_ready        - consumer accepts the word
//                overrun           - sticky word-dropped flag
//                clear_overrun     - synchronous clear of overrun
//                bit_count         - bits held in the partial word
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            serial_in,
    input  logic                            serial_valid,
    input  logic                            frame_start,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            data_valid,
    input  logic                            data_ready,
    output logic                            overrun,
    input  logic                            clear_overrun,
    output logic [CNT_W(DATA_WIDTH)-1:0]    bit_count
);

    buf_state_t            r_state;
    buf_state_t            w_state_next;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_overrun;
    logic                  w_word_done;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_handshake;
    logic                  w_load;
    logic                  w_drop;

    sipo_shift_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_core (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .word_done    (w_word_done),
        .word         (w_word),
        .bit_count    (bit_count)
    );

    assign w_handshake = (r_state == BUF_FULL) && data_ready;
    // A completing word may enter the buffer if it is empty or being drained
    // at this same edge; otherwise it is lost.
    assign w_load      = w_word_done && ((r_state == BUF_EMPTY) || data_ready);
    assign w_drop      = w_word_done && (r_state == BUF_FULL) && !data_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BUF_EMPTY: if (w_word_done)                 w_state_next = BUF_FULL;
            BUF_FULL:  if (w_handshake && !w_word_done) w_state_next = BUF_EMPTY;
            default:                                    w_state_next = BUF_EMPTY;
        endcase
    end

    // Output logic (decoded from the state register only)
    always_comb begin
        data_valid = (r_state == BUF_FULL);
    end

    // Buffer data and sticky overrun; a drop takes priority over a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_data <= w_word;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clear_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign data_out = r_data;
    assign overrun  = r_overrun;

endmodule : sipo_deser
`default_nettype wire

// File: doc/sipo_deser.md
# sipo_deser

Serial-in, parallel-out deserializer: the receive-side counterpart of the team's parallel-to-serial shifter. It collects a qualified serial bit stream into DATA_WIDTH-bit words and presents each word on a one-entry valid/ready output buffer. A sticky error flag reports words lost to backpressure. It sits between the serial link front end and the word-oriented datapath.

## Interface
- DATA_WIDTH, 8: word width in bits, at least 2.
- MSB_FIRST, 1: when 1, the first received bit lands in data_out[DATA_WIDTH-1]; when 0, it lands in data_out[0].
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high.
- serial_in  in  1  serial data bit, sampled only when serial_valid=1.
- serial_valid  in  1  bit strobe; exactly one bit is accepted per cycle in which it is high.
- frame_start  in  1  qualified by serial_valid; marks the current bit as bit 0 of a new word.
- data_out  out  DATA_WIDTH  assembled word; stable while data_valid=1.
- data_valid  out  1  the output buffer holds a word.
- data_ready  in  1  consumer accepts the word on a cycle where data_valid=1 and data_ready=1.
- overrun  out  1  sticky: a completed word was dropped.
- clear_overrun  in  1  synchronous clear of overrun.
- bit_count  out  $clog2(DATA_WIDTH)  number of bits collected so far in the partial word.

## Operation
- Assembly
  - shift_reg collects bits; bit_count increments on each accepted bit.
  - MSB_FIRST=1: shift left, new bit enters at LSB. MSB_FIRST=0: shift right, new bit enters at MSB.
  - On the DATA_WIDTH-th accepted bit, the word is complete: the completed value including that bit goes to the output buffer, and bit_count wraps to 0.
- frame_start with serial_valid=1
  - Any partial word is discarded silently; the current bit becomes bit 0 and bit_count becomes 1.
  - If DATA_WIDTH=… (this edge case is excluded by the DATA_WIDTH≥2 rule).
  - frame_start with serial_valid=0 is ignored.
- Output buffer FSM, two states
  - EMPTY: data_valid=0. A completed word loads the buffer, and the state moves to FULL.
  - FULL: data_valid=1.
    - A handshake with no completing word moves to EMPTY.
    - A handshake in the same cycle as a completing word loads the new word and stays FULL. No overrun is raised.
    - A completing word without a handshake is dropped, overrun is set, and the buffer keeps its old word.
- overrun
  - Set wins over a simultaneous clear_overrun.
  - Otherwise clear_overrun clears it on the next edge.
- Reset, including mid-word or mid-handshake
  - shift_reg=0, bit_count=0, state EMPTY.
  - data_out=0, data_valid=0, overrun=0.
  - The partial word is lost.

## Timing
- All outputs are registered.
- Latency: if the last bit is sampled at edge n, data_valid=1 and data_out is valid immediately after edge n.
- A word is consumed at the edge where data_valid and data_ready are both 1; data_valid falls after that edge unless a new word loads at the same edge.
- Sustained throughput: one word per DATA_WIDTH strobes, with no loss when data_ready is held at 1.
- data_ready may be high while data_valid=0; it has no effect.
- data_out is held constant while FULL with no handshake.

## Structure
- Package sipo_pkg holds:
  - CNT_W(width) as a constant function.
  - The buffer state enum {BUF_EMPTY, BUF_FULL}.
- One sub-module, sipo_shift_core, contains the shift register and bit counter and raises word_done with the word.
- sipo_deser owns the output buffer FSM and the overrun logic.

## Test plan
- Reset checks:
  - Assert reset asynchronously mid-word, after 3 bits, while FULL with overrun=1. All outputs must be 0 immediately.
  - After release, a fresh 8-bit word must assemble correctly.
- MSB_FIRST=1, data_ready=1: bits 1,0,1,0,0,1,0,1 on consecutive strobes give data_out=0xA5 with data_valid high for one cycle, one edge after the 8th bit. With MSB_FIRST=0, the same stream gives 0xA5 bit-reversed = 0xA5.
  - Use 1,1,0,0,0,0,0,0 instead to distinguish: MSB_FIRST=1 gives 0xC0, MSB_FIRST=0 gives 0x03.
- Gapped strobes: insert random idle cycles between bits. data_out must be unaffected and bit_count must hold during gaps.
- frame_start resync: send 5 bits, then frame_start on the next bit followed by 0x3C MSB-first. Output must be exactly one word, 0x3C.
- Backpressure:
  - Hold data_ready=0 and send 0x11 then 0x22. data_out must stay 0x11 and overrun must rise after the 0x22 completes.
  - Then pulse data_ready: data_valid drops.
  - Then clear_overrun: overrun returns to 0.
- Simultaneous events:
  - data_ready=1 on the exact edge the next word completes: the new word loads, data_valid stays 1, and overrun stays 0.
  - clear_overrun coincident with a new drop: overrun stays 1.
